// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: synchronises raw IRQ lines, latches them into a masked
// pending set for the external priority encoder, and runs the CPU ack/EOI handshake.
//
// state   | meaning
// IDLE    | no request outstanding; waits for the encoder to report a pending source
// REQ     | o_irq asserted; waiting for CPU ack (or for the pending set to vanish)
// SERV    | source o_vec in service; new pends accumulate until EOI
module irq_pending_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_irq,
    input  logic       i_mask_we,
    input  logic [3:0] i_mask_wdata,
    input  logic [1:0] i_enc_addr,
    input  logic       i_enc_zero,
    input  logic       i_ack,
    input  logic       i_eoi,
    output logic [3:0] o_pend,
    output logic       o_irq,
    output logic [1:0] o_vec,
    output logic       o_busy,
    output logic [3:0] o_mask
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_SERV = 2'd2;

    logic [3:0] r_sync [SYNC_STAGES];
    logic [3:0] r_hist;
    logic [3:0] r_pend;
    logic [3:0] r_mask;
    logic [1:0] r_state;
    logic       r_irq;
    logic       r_busy;
    logic [1:0] r_vec;

    logic [3:0] w_sync;
    logic [3:0] w_set;
    logic [3:0] w_clr;
    logic       w_ack_take;
    logic [1:0] w_state_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 4'b0000;
            end
            r_hist <= 4'b0000;
        end else begin
            r_sync[0] <= i_irq;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= w_sync;
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_set  = (EDGE_MODE != 0) ? (w_sync & ~r_hist) : w_sync;

    // An ack is only honoured in REQ with a valid encoder result.
    assign w_ack_take = (r_state == ST_REQ) && i_ack && !i_enc_zero;
    assign w_clr      = w_ack_take ? (4'b0001 << i_enc_addr) : 4'b0000;

    // Set is OR-ed in after the clear so a fresh event on the acked bit survives.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend <= 4'b0000;
            r_mask <= 4'b0000;
        end else begin
            r_pend <= (r_pend & ~w_clr) | w_set;
            if (i_mask_we) begin
                r_mask <= i_mask_wdata;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!i_enc_zero) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_take) begin
                    w_state_nxt = ST_SERV;
                end else if (i_enc_zero) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SERV: begin
                if (i_eoi) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_irq   <= 1'b0;
            r_busy  <= 1'b0;
            r_vec   <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= (w_state_nxt == ST_REQ);
            r_busy  <= (w_state_nxt == ST_SERV);
            if (w_ack_take) begin
                r_vec <= i_enc_addr;
            end
        end
    end

    assign o_pend = r_pend & r_mask;
    assign o_irq  = r_irq;
    assign o_vec  = r_vec;
    assign o_busy = r_busy;
    assign o_mask = r_mask;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: two instances (edge/2-stage and level/1-stage) checked
// every cycle against a sample-history model, plus directed literal scenarios.
module tb_irq_pending_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       ack_a, eoi_a, ack_b, eoi_b;
    logic [1:0] enc_addr_a, enc_addr_b;
    logic       enc_zero_a, enc_zero_b;
    logic [3:0] o_pend_a, o_pend_b, o_mask_a, o_mask_b;
    logic       o_irq_a, o_irq_b, o_busy_a, o_busy_b;
    logic [1:0] o_vec_a, o_vec_b;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;
    bit auto_b = 1;

    always #5 clk = ~clk;

    irq_pending_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
        .i_enc_addr(enc_addr_a), .i_enc_zero(enc_zero_a), .i_ack(ack_a), .i_eoi(eoi_a),
        .o_pend(o_pend_a), .o_irq(o_irq_a), .o_vec(o_vec_a), .o_busy(o_busy_a), .o_mask(o_mask_a)
    );

    irq_pending_ctrl #(.SYNC_STAGES(1), .EDGE_MODE(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_irq(irq), .i_mask_we(mask_we), .i_mask_wdata(mask_wdata),
        .i_enc_addr(enc_addr_b), .i_enc_zero(enc_zero_b), .i_ack(ack_b), .i_eoi(eoi_b),
        .o_pend(o_pend_b), .o_irq(o_irq_b), .o_vec(o_vec_b), .o_busy(o_busy_b), .o_mask(o_mask_b)
    );

    // Model: raw samples of i_irq (index 0 = newest), pending set, mask, handshake phase.
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_SERV = 2;

    logic [3:0] m_hist [2][4];
    logic [3:0] m_pend [2];
    logic [3:0] m_mask [2];
    logic [1:0] m_vec  [2];
    int         m_phase [2];

    function automatic logic [1:0] top_idx(input logic [3:0] v);
        if (v[3]) return 2'd3;
        if (v[2]) return 2'd2;
        if (v[1]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic [11:0] pk(input logic [3:0] p, input logic i, input logic [1:0] v,
                                       input logic b, input logic [3:0] m);
        return {p, i, v, b, m};
    endfunction

    function automatic logic [11:0] exp_pk(input int k);
        return pk(m_pend[k] & m_mask[k], m_phase[k] == PH_REQ, m_vec[k], m_phase[k] == PH_SERV, m_mask[k]);
    endfunction

    task automatic model_step(input int k, input logic ack, input logic eoi);
        int         ss;
        logic [3:0] s, h, setv, vis, clr;
        logic       take;
        ss = (k == 0) ? 2 : 1;
        if (rst) begin
            for (int j = 0; j < 4; j++) m_hist[k][j] = 4'b0;
            m_pend[k]  = 4'b0;
            m_mask[k]  = 4'b0;
            m_vec[k]   = 2'b0;
            m_phase[k] = PH_IDLE;
        end else begin
            s    = m_hist[k][ss-1];
            h    = m_hist[k][ss];
            setv = (k == 0) ? (s & ~h) : s;
            vis  = m_pend[k] & m_mask[k];
            take = (m_phase[k] == PH_REQ) && ack && (vis != 4'b0);
            clr  = take ? (4'b0001 << top_idx(vis)) : 4'b0;
            m_pend[k] = (m_pend[k] & ~clr) | setv;
            for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
            m_hist[k][0] = irq;
            if (take) m_vec[k] = top_idx(vis);
            if (m_phase[k] == PH_IDLE) begin
                if (vis != 4'b0) m_phase[k] = PH_REQ;
            end else if (m_phase[k] == PH_REQ) begin
                if (take) m_phase[k] = PH_SERV;
                else if (vis == 4'b0) m_phase[k] = PH_IDLE;
            end else begin
                if (eoi) m_phase[k] = PH_IDLE;
            end
            if (mask_we) m_mask[k] = mask_wdata;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, ack_a, eoi_a);
        model_step(1, ack_b, eoi_b);
    end

    // The encoder is external; emulate it from the model's masked pending set.
    always @(negedge clk) begin
        enc_zero_a = (m_pend[0] & m_mask[0]) == 4'b0;
        enc_addr_a = top_idx(m_pend[0] & m_mask[0]);
        enc_zero_b = (m_pend[1] & m_mask[1]) == 4'b0;
        enc_addr_b = top_idx(m_pend[1] & m_mask[1]);
    end

    always @(negedge clk) begin
        if (auto_b) begin
            ack_b = ($urandom_range(0, 2) == 0);
            eoi_b = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (pend,irq,vec,busy,mask)", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_a", pk(o_pend_a, o_irq_a, o_vec_a, o_busy_a, o_mask_a), exp_pk(0));
            chk("model_b", pk(o_pend_b, o_irq_b, o_vec_b, o_busy_b, o_mask_b), exp_pk(1));
        end
    end

    function automatic logic [11:0] act_a();
        return pk(o_pend_a, o_irq_a, o_vec_a, o_busy_a, o_mask_a);
    endfunction

    function automatic logic [11:0] act_b();
        return pk(o_pend_b, o_irq_b, o_vec_b, o_busy_b, o_mask_b);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; irq = 4'b0; mask_we = 1'b0; ack_a = 1'b0; eoi_a = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_mask(input logic [3:0] v);
        mask_we = 1'b1; mask_wdata = v;
        step();
        mask_we = 1'b0;
    endtask

    task automatic wait_irq_a(input string name);
        for (int i = 0; i < 12 && o_irq_a !== 1'b1; i++) step();
        chk(name, {11'b0, o_irq_a}, 12'd1);
    endtask

    initial begin
        rst = 1'b1; irq = 4'hF; mask_we = 1'b0; mask_wdata = 4'h0;
        ack_a = 1'b0; eoi_a = 1'b0; ack_b = 1'b0; eoi_b = 1'b0;
        step(); step(); step();
        chk_en = 1;
        chk("t1_reset", act_a(), pk(4'h0, 1'b0, 2'd0, 1'b0, 4'h0));
        rst = 1'b0;
        repeat (5) step();
        set_mask(4'hF);
        chk("t1_mask_pend", act_a(), pk(4'hF, 1'b0, 2'd0, 1'b0, 4'hF));
        step();
        chk("t1_irq", act_a(), pk(4'hF, 1'b1, 2'd0, 1'b0, 4'hF));

        do_reset(); set_mask(4'hF);
        irq = 4'b0010; step();
        irq = 4'b0000; step();
        chk("t2_not_yet", act_a(), pk(4'h0, 1'b0, 2'd0, 1'b0, 4'hF));
        step();
        chk("t2_pend", act_a(), pk(4'b0010, 1'b0, 2'd0, 1'b0, 4'hF));
        step();
        chk("t2_irq", act_a(), pk(4'b0010, 1'b1, 2'd0, 1'b0, 4'hF));
        ack_a = 1'b1; step(); ack_a = 1'b0;
        chk("t2_ack", act_a(), pk(4'h0, 1'b0, 2'd1, 1'b1, 4'hF));
        eoi_a = 1'b1; step(); eoi_a = 1'b0;
        chk("t2_eoi", act_a(), pk(4'h0, 1'b0, 2'd1, 1'b0, 4'hF));
        step();
        chk("t2_idle", act_a(), pk(4'h0, 1'b0, 2'd1, 1'b0, 4'hF));

        do_reset(); set_mask(4'hF);
        irq = 4'b1001;
        wait_irq_a("t3_wait");
        ack_a = 1'b1; step(); ack_a = 1'b0;
        chk("t3_ack_hi", act_a(), pk(4'b0001, 1'b0, 2'd3, 1'b1, 4'hF));
        eoi_a = 1'b1; step(); eoi_a = 1'b0;
        chk("t3_eoi", act_a(), pk(4'b0001, 1'b0, 2'd3, 1'b0, 4'hF));
        step();
        chk("t3_rereq", act_a(), pk(4'b0001, 1'b1, 2'd3, 1'b0, 4'hF));
        ack_a = 1'b1; step(); ack_a = 1'b0;
        chk("t3_ack_lo", act_a(), pk(4'h0, 1'b0, 2'd0, 1'b1, 4'hF));
        eoi_a = 1'b1; step(); eoi_a = 1'b0;

        auto_b = 0; ack_b = 1'b0; eoi_b = 1'b0;
        do_reset(); set_mask(4'hF);
        irq = 4'b0100; step(); step();
        chk("t4_b_pend", act_b(), pk(4'b0100, 1'b0, 2'd0, 1'b0, 4'hF));
        step();
        chk("t4_b_irq", act_b(), pk(4'b0100, 1'b1, 2'd0, 1'b0, 4'hF));
        ack_b = 1'b1; step(); ack_b = 1'b0;
        chk("t4_b_ack_reset", act_b(), pk(4'b0100, 1'b0, 2'd2, 1'b1, 4'hF));
        step();
        chk("t4_b_sticky", act_b(), pk(4'b0100, 1'b0, 2'd2, 1'b1, 4'hF));
        chk("t4_a_irq", act_a(), pk(4'b0100, 1'b1, 2'd0, 1'b0, 4'hF));
        ack_a = 1'b1; step(); ack_a = 1'b0;
        chk("t4_a_ack", act_a(), pk(4'h0, 1'b0, 2'd2, 1'b1, 4'hF));
        eoi_a = 1'b1; step(); eoi_a = 1'b0;
        repeat (15) step();
        chk("t4_a_once", act_a(), pk(4'h0, 1'b0, 2'd2, 1'b0, 4'hF));
        eoi_b = 1'b1; step(); eoi_b = 1'b0;
        auto_b = 1;

        do_reset(); set_mask(4'hF);
        irq = 4'b0001;
        wait_irq_a("t5_wait");
        set_mask(4'h0);
        step();
        chk("t5_drop", act_a(), pk(4'h0, 1'b0, 2'd0, 1'b0, 4'h0));
        set_mask(4'h1);
        chk("t5_kept", act_a(), pk(4'b0001, 1'b0, 2'd0, 1'b0, 4'h1));
        step();
        chk("t5_rereq", act_a(), pk(4'b0001, 1'b1, 2'd0, 1'b0, 4'h1));

        do_reset(); set_mask(4'hF);
        irq = 4'b0100;
        wait_irq_a("t6_wait");
        irq = 4'b0000; step(); step(); step();
        irq = 4'b0100; step(); step();
        ack_a = 1'b1; step(); ack_a = 1'b0;
        chk("t6_set_wins", act_a(), pk(4'b0100, 1'b0, 2'd2, 1'b1, 4'hF));
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_rst_serv", act_a(), pk(4'h0, 1'b0, 2'd0, 1'b0, 4'h0));

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            end
            mask_we    = ($urandom_range(0, 9) == 0);
            mask_wdata = 4'($urandom | $urandom);
            ack_a      = ($urandom_range(0, 2) == 0);
            eoi_a      = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
